note_text_streamer: RTL and testbench
=====================================

NOTE_TEXT_STREAMER -- requirements
Module: note_text_streamer

Interface
REQ-001 SHALL have parameter FIELD_W, default 4: LCD field width in characters, legal 4..16.
REQ-002 SHALL have parameter LEFT_JUST, default 0: 0 pads the name with spaces on the left, 1 pads on the right.
REQ-003 SHALL have parameter STABLE_CYC, default 16: input stability window in clocks, legal 1..65535, used only with NOTE_STABLE_EN.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port note_in, input, 4 bits: [0] is sound enable and [3:1] selects the note.
REQ-007 SHALL have port char_data, output, 8 bits: ASCII character being offered.
REQ-008 SHALL have port char_pos, output, $clog2(FIELD_W) bits: field column of char_data, where 0 is the leftmost column.
REQ-009 SHALL have port char_valid, output, 1 bit: character offer is valid.
REQ-010 SHALL have port char_ready, input, 1 bit: downstream LCD writer accepts the offer.
REQ-011 SHALL have port field, output, 8*FIELD_W bits: the complete latched text, with column 0 in the MS byte.
REQ-012 SHALL have port busy, output, 1 bit: high while a stream is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last character is accepted.

Function
REQ-014 SHALL resolve the note code as follows: if note_in[0]=0, the code is BLANK; otherwise note_in[3:1] maps 000 to "Do1", 001 to "Re", 010 to "Mi", 100 to "Fa", 011 to "Sol", 101 to "La", 110 to "Si" and 111 to "Do2".
REQ-015 SHALL treat BLANK as FIELD_W spaces (0x20).
REQ-016 SHALL build the field from the name in ASCII ("D"=0x44, "o"=0x6F, "1"=0x31 and so on), padded to FIELD_W with 0x20 according to LEFT_JUST.
REQ-017 SHALL implement an FSM with states IDLE, LOAD, SEND and DONE.
REQ-018 SHALL, in IDLE, go to LOAD in the next cycle when the accepted code differs from the last streamed code.
REQ-019 SHALL, in LOAD, latch the accepted code as the last streamed code, load field, set char_pos=0, and go to SEND.
REQ-020 SHALL, in SEND, hold char_valid=1 and keep char_data and char_pos stable until char_ready=1 is sampled.
REQ-021 SHALL, on each accepted transfer (char_valid & char_ready) with char_pos<FIELD_W-1, increment char_pos.
REQ-022 SHALL, on the accepted transfer with char_pos=FIELD_W-1, drop char_valid and go to DONE.
REQ-023 SHALL, in DONE, assert done for exactly one cycle and then return to IDLE.
REQ-024 SHALL drive busy=1 in the LOAD, SEND and DONE states.
REQ-025 SHALL set char_data = byte char_pos of field, registered, with no combinational path from note_in.
REQ-026 SHALL ignore note_in changes during LOAD, SEND and DONE, leaving field unaltered mid-stream.
REQ-027 SHALL, if the code still differs from the last streamed code on IDLE entry, restart at LOAD on the following cycle, so only the final value is streamed.
REQ-028 SHALL produce a minimum stream of FIELD_W+3 cycles from IDLE exit to IDLE re-entry when char_ready is held at 1.
REQ-029 SHALL ignore char_ready while char_valid=0.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force char_valid=0, char_data=0x20, char_pos=0, busy=0, done=0 and field to all 0x20.
REQ-031 SHALL, while rst_n=0, hold the FSM in LOAD with the last streamed code set to an INVALID sentinel and the accepted code set to BLANK.
REQ-032 SHALL, after rst_n rises, stream the current code once so the LCD is always initialised (spaces if note_in[0]=0).
REQ-033 SHALL, on reset assertion mid-stream, abandon the stream immediately without completing the handshake.

Configuration
REQ-034 SHALL, with NOTE_STABLE_EN defined, update the accepted code only after the resolved code has been unchanged for STABLE_CYC consecutive clocks, using a 16-bit counter that resets on any change and saturates.
REQ-035 SHALL, without NOTE_STABLE_EN, make the accepted code the resolved code registered once, with no stability counter synthesised.

Verification
REQ-036 SHALL cover reset release with note_in=0000 and char_ready=1: the bench sees four offers of 0x20 at pos 0..3, then one done pulse.
REQ-037 SHALL cover note_in=0111 with FIELD_W=4, LEFT_JUST=0 and char_ready=1: offers are 0x20, 0x53, 0x6F, 0x6C, and field=0x20536F6C.
REQ-038 SHALL cover note_in=1111 with FIELD_W=6, LEFT_JUST=1: field is 0x446F32202020.
REQ-039 SHALL cover char_ready held low for 5 cycles at pos 1: char_valid, char_data and char_pos stay constant, and there is no skip or duplicate after release.
REQ-040 SHALL cover note_in toggling 0011 -> 0101 -> 1011 during SEND: the first stream completes as "Re", then exactly one "La" stream follows and no "Mi" stream.
REQ-041 SHALL cover NOTE_STABLE_EN with STABLE_CYC=16 and a 10-cycle glitch to 0101 from 0011: no new stream, while a hold of 16 or more cycles produces a "Mi" stream.

Source files
------------

// File: rtl/note_text_streamer.sv
// Streams the note name for the selected tone as FIELD_W ASCII columns through a valid/ready port.
// Optional input stability filter: define NOTE_STABLE_EN.
module note_text_streamer #(
    parameter int FIELD_W    = 4,
    parameter int LEFT_JUST  = 0,
    parameter int STABLE_CYC = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 note_in,
    output logic [7:0]                 char_data,
    output logic [$clog2(FIELD_W)-1:0] char_pos,
    output logic                       char_valid,
    input  logic                       char_ready,
    output logic [8*FIELD_W-1:0]       field,
    output logic                       busy,
    output logic                       done
);

    localparam int POS_W = $clog2(FIELD_W);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(FIELD_W - 1);

    // Internal codes: 0..7 follow note_in[3:1], then BLANK and the never-resolved INVALID.
    localparam logic [3:0] CODE_BLANK   = 4'd8;
    localparam logic [3:0] CODE_INVALID = 4'd15;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    if (FIELD_W < 4 || FIELD_W > 16 || STABLE_CYC < 1 || STABLE_CYC > 65535) begin : g_param_check
        $error("note_text_streamer: FIELD_W or STABLE_CYC out of range");
    end

    state_t     state;
    logic [3:0] resolved;
    logic [3:0] accepted;
    logic [3:0] last_code;

    function automatic logic [8*FIELD_W-1:0] build_field(input logic [3:0] code);
        logic [23:0]          name;
        int unsigned          len;
        logic [7:0]           ch;
        logic [8*FIELD_W-1:0] f;
        len  = 0;
        name = '0;
        f    = '0;
        case (code)
            4'd0: begin name = "Do1";          len = 3; end
            4'd1: begin name = {"Re",  8'h00}; len = 2; end
            4'd2: begin name = {"Mi",  8'h00}; len = 2; end
            4'd3: begin name = "Sol";          len = 3; end
            4'd4: begin name = {"Fa",  8'h00}; len = 2; end
            4'd5: begin name = {"La",  8'h00}; len = 2; end
            4'd6: begin name = {"Si",  8'h00}; len = 2; end
            4'd7: begin name = "Do2";          len = 3; end
            default: begin name = '0;          len = 0; end
        endcase
        for (int unsigned c = 0; c < unsigned'(FIELD_W); c++) begin
            ch = 8'h20;
            if (LEFT_JUST != 0) begin
                if (c < len) ch = name[23-8*c -: 8];
            end else if (c >= unsigned'(FIELD_W) - len) begin
                ch = name[23-8*(c-(unsigned'(FIELD_W)-len)) -: 8];
            end
            f[8*(unsigned'(FIELD_W)-1-c) +: 8] = ch;
        end
        return f;
    endfunction

    function automatic logic [7:0] byte_at(input logic [8*FIELD_W-1:0] f, input logic [POS_W-1:0] p);
        return f[8*(FIELD_W-1-int'(p)) +: 8];
    endfunction

    always_comb begin
        resolved = note_in[0] ? {1'b0, note_in[3:1]} : CODE_BLANK;
    end

`ifdef NOTE_STABLE_EN
    localparam logic [15:0] STABLE_M1 = 16'(STABLE_CYC - 1);

    logic [3:0]  candidate;
    logic [15:0] stable_cnt;

    // stable_cnt holds how many clocks candidate has already been seen unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate  <= CODE_BLANK;
            stable_cnt <= '0;
            accepted   <= CODE_BLANK;
        end else if (resolved != candidate) begin
            candidate  <= resolved;
            stable_cnt <= 16'd1;
            if (STABLE_CYC == 1) accepted <= resolved;
        end else begin
            if (stable_cnt != '1) stable_cnt <= stable_cnt + 16'd1;
            if (stable_cnt >= STABLE_M1) accepted <= candidate;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) accepted <= CODE_BLANK;
        else        accepted <= resolved;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            last_code  <= CODE_INVALID;
            field      <= {FIELD_W{8'h20}};
            char_data  <= 8'h20;
            char_pos   <= '0;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accepted != last_code) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    busy       <= 1'b1;
                    last_code  <= accepted;
                    field      <= build_field(accepted);
                    char_pos   <= '0;
                    char_data  <= byte_at(build_field(accepted), '0);
                    char_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (char_ready) begin
                        if (char_pos == LAST_POS) begin
                            char_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            char_pos  <= char_pos + 1'b1;
                            char_data <= byte_at(field, char_pos + 1'b1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_text_streamer.sv
// Scoreboard bench for note_text_streamer: expected offers are queued when notes are driven.
// Define NOTE_STABLE_EN on both files to exercise the stability filter.
module tb_note_text_streamer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  note_in;
    logic [7:0]  char_data;
    logic [1:0]  char_pos;
    logic        char_valid;
    logic        char_ready;
    logic [31:0] field;
    logic        busy;
    logic        done;

    logic [7:0]  w_data;
    logic [2:0]  w_pos;
    logic        w_valid;
    logic        w_ready;
    logic [47:0] w_field;
    logic        w_busy;
    logic        w_done;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [15:0] exp_q[$];

    note_text_streamer #(.FIELD_W(4), .LEFT_JUST(0), .STABLE_CYC(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .note_in(note_in),
        .char_data(char_data), .char_pos(char_pos), .char_valid(char_valid),
        .char_ready(char_ready), .field(field), .busy(busy), .done(done)
    );

    note_text_streamer #(.FIELD_W(6), .LEFT_JUST(1), .STABLE_CYC(16)) u_wide (
        .clk(clk), .rst_n(rst_n), .note_in(note_in),
        .char_data(w_data), .char_pos(w_pos), .char_valid(w_valid),
        .char_ready(w_ready), .field(w_field), .busy(w_busy), .done(w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Column 0 is the MS byte of txt.
    task automatic push_text(input logic [31:0] txt);
        for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), txt[31-8*i -: 8]});
    endtask

    task automatic set_note(input logic [3:0] v);
        @(posedge clk);
        #1 note_in = v;
    endtask

    task automatic drain(input int n_done, input string tag);
        int start;
        int t;
        start = done_cnt;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_timeout"}, 64'(t < 400), 64'd1);
        repeat (12) @(negedge clk);
        check_eq({tag, "_done_pulses"}, 64'(done_cnt - start), 64'(n_done));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (char_valid && char_ready) begin
                check_eq("offer_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check_eq("char_data", 64'(char_data), 64'(e[7:0]));
                    check_eq("char_pos", 64'(char_pos), 64'(e[15:8]));
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        rst_n      = 1'b0;
        note_in    = 4'b0000;
        char_ready = 1'b1;
        w_ready    = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 64'(char_valid), 64'd0);
        check_eq("rst_data",  64'(char_data),  64'h20);
        check_eq("rst_pos",   64'(char_pos),   64'd0);
        check_eq("rst_busy",  64'(busy),       64'd0);
        check_eq("rst_done",  64'(done),       64'd0);
        check_eq("rst_field", 64'(field),      64'h20202020);

        push_text(32'h20202020);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain(1, "init");

        set_note(4'b0111);
        push_text(32'h20536F6C);
        drain(1, "sol");
        check_eq("sol_field", 64'(field), 64'h20536F6C);

        set_note(4'b1111);
        push_text(32'h20446F32);
        drain(1, "do2");
        check_eq("do2_field", 64'(field), 64'h20446F32);
        check_eq("do2_wide_field", 64'(w_field), 64'h446F32202020);

        set_note(4'b0101);
        push_text(32'h20204D69);
        t = 0;
        do begin
            @(posedge clk);
            #1 t++;
        end while (!(char_valid && char_pos == 2'd1) && t < 200);
        check_eq("stall_reach", 64'(t < 200), 64'd1);
        char_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_valid", 64'(char_valid), 64'd1);
            check_eq("stall_data",  64'(char_data),  64'h20);
            check_eq("stall_pos",   64'(char_pos),   64'd1);
        end
        @(posedge clk);
        #1 char_ready = 1'b1;
        drain(1, "stall");

        set_note(4'b0011);
        push_text(32'h20205265);
        t = 0;
        do begin
            @(posedge clk);
            #1 t++;
        end while (!char_valid && t < 200);
        check_eq("toggle_reach", 64'(t < 200), 64'd1);
        note_in = 4'b0101;
        @(posedge clk);
        #1 note_in = 4'b1011;
        push_text(32'h20204C61);
        drain(2, "toggle");
        check_eq("toggle_field", 64'(field), 64'h20204C61);

`ifdef NOTE_STABLE_EN
        set_note(4'b0011);
        push_text(32'h20205265);
        drain(1, "stable_re");
        set_note(4'b0101);
        repeat (9) @(posedge clk);
        #1 note_in = 4'b0011;
        begin
            int start;
            start = done_cnt;
            repeat (40) @(negedge clk);
            check_eq("glitch_no_stream", 64'(done_cnt - start), 64'd0);
        end
        set_note(4'b0101);
        push_text(32'h20204D69);
        drain(1, "stable_mi");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
